// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry,
// flush-to-bubble, and a saturating back-pressure cycle counter.
module pipe_stage_reg #(
  parameter int unsigned CW       = 16,
  parameter int unsigned DW       = 32,
  parameter bit          CLR_DATA = 1'b0,
  parameter bit          SKID     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ctrl,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ctrl,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy,
  output logic [15:0]   stall_cnt,
  input  logic          cnt_clr
);

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  entry_t      m_q, m_d;     // main entry, drives outputs
  entry_t      s_q, s_d;     // skid entry, stays empty when SKID=0
  logic [15:0] cnt_q, cnt_d;
  logic        acc, pop;
  entry_t      in_e;

  assign in_e = '{vld: 1'b1, ctrl: in_ctrl, data: in_data};

  // With a skid entry in_ready is purely registered; without it, ready
  // looks through to out_ready so the single entry can stream.
  assign in_ready  = SKID ? !s_q.vld : (!m_q.vld || out_ready);
  assign acc       = in_valid && in_ready;
  assign pop       = m_q.vld && out_ready;

  assign out_valid = m_q.vld;
  assign out_ctrl  = m_q.ctrl;
  assign out_data  = m_q.data;
  assign occupancy = {1'b0, m_q.vld} + {1'b0, s_q.vld};
  assign stall_cnt = cnt_q;

  // Next-state for both entries; flush wins, and an emptied entry is a bubble
  // (ctrl zero) whose data is kept unless CLR_DATA asks for zeroing.
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (flush) begin
      m_d.vld  = 1'b0;
      m_d.ctrl = '0;
      s_d.vld  = 1'b0;
      s_d.ctrl = '0;
      if (CLR_DATA) begin
        m_d.data = '0;
        s_d.data = '0;
      end
    end else if (SKID) begin
      if (pop) begin
        if (s_q.vld) begin
          m_d = s_q;
        end else if (acc) begin
          m_d = in_e;
        end else begin
          m_d.vld  = 1'b0;
          m_d.ctrl = '0;
          if (CLR_DATA) m_d.data = '0;
        end
        s_d.vld  = 1'b0;
        s_d.ctrl = '0;
        if (CLR_DATA) s_d.data = '0;
      end else if (acc) begin
        // S is only filled behind a valid M, keeping FIFO order.
        if (!m_q.vld) m_d = in_e;
        else          s_d = in_e;
      end
    end else begin
      if (acc) begin
        m_d = in_e;
      end else if (pop) begin
        m_d.vld  = 1'b0;
        m_d.ctrl = '0;
        if (CLR_DATA) m_d.data = '0;
      end
    end
  end

  // Back-pressure counter: clear beats increment, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                                      cnt_d = '0;
    else if (m_q.vld && !out_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // State registers; reset zeroes data too, regardless of CLR_DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
